spi_slave_frontend: RTL

SPI slave front-end that sits directly upstream of the single-port RAM in the SPI wrapper. Deserialises 10-bit MOSI frames (2-bit command + 8-bit payload) into a parallel word with a one-cycle valid strobe for the RAM. For read-data commands it also captures the RAM's returned byte and serialises it onto MISO. The SPI serial clock and the system clock are the same `clk`.

---
 rtl/spi_slave_frontend.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_slave_frontend.sv
// rtl/spi_slave_frontend.sv - SPI slave front-end: MOSI frame deserialiser and MISO read-byte serialiser
//
// Ports:
//   clk       system / SPI clock, rising edge
//   rst       synchronous active-high reset
//   SS_n      slave select, active low, frames the transfer
//   MOSI      serial data in, MSB first
//   MISO      serial data out, MSB first
//   rx_data   completed frame {cmd[1:0], payload}
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_data   read byte returned by the RAM
//   tx_valid  strobe qualifying tx_data
module spi_slave_frontend #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FRAME_W = DATA_W + 2;
    // bit_cnt holds the number of frame bits already taken in
    localparam logic [3:0] LAST_RX = 4'(FRAME_W - 1);
    localparam logic [3:0] RX_DONE = 4'(FRAME_W);
    // tx_cnt: 0 = waiting for the RAM byte, 1..DATA_W-1 = shifting,
    // DATA_W = final edge that returns MISO to 0, DATA_W+1 = finished
    localparam logic [3:0] TX_LAST = 4'(DATA_W);
    localparam logic [3:0] TX_DONE = 4'(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state, next_state;

    logic [3:0]         bit_cnt;
    logic [3:0]         tx_cnt;
    logic [FRAME_W-1:0] shift_in;
    logic [DATA_W-2:0]  tx_shift;
    logic               rd_addr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)              next_state = IDLE;
                else if (!MOSI)        next_state = WRITE;
                else if (rd_addr_done) next_state = READ_DATA;
                else                   next_state = READ_ADD;
            end
            default: begin
                if (SS_n) next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            tx_cnt       <= '0;
            shift_in     <= '0;
            tx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                // Abort or idle: drop any partial frame, keep rd_addr_done
                // so an interrupted read-data frame can be retried.
                bit_cnt  <= '0;
                tx_cnt   <= '0;
                shift_in <= '0;
                tx_shift <= '0;
                MISO     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                    end
                    CHK_CMD: begin
                        shift_in <= {shift_in[FRAME_W-2:0], MOSI};
                        bit_cnt  <= 4'd1;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt < RX_DONE) begin
                            shift_in <= {shift_in[FRAME_W-2:0], MOSI};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_RX) begin
                                rx_data  <= {shift_in[FRAME_W-2:0], MOSI};
                                rx_valid <= 1'b1;
                                if (state == READ_ADD) rd_addr_done <= 1'b1;
                            end
                        end else if (state == READ_DATA) begin
                            if (tx_cnt == 4'd0) begin
                                if (tx_valid) begin
                                    MISO     <= tx_data[DATA_W-1];
                                    tx_shift <= tx_data[DATA_W-2:0];
                                    tx_cnt   <= 4'd1;
                                end
                            end else if (tx_cnt < TX_LAST) begin
                                MISO     <= tx_shift[DATA_W-2];
                                tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
                                tx_cnt   <= tx_cnt + 4'd1;
                            end else if (tx_cnt == TX_LAST) begin
                                MISO         <= 1'b0;
                                rd_addr_done <= 1'b0;
                                tx_cnt       <= TX_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
